// File: rtl/axi4_mem_responder.sv
// AXI4 slave backed by a 32-bit word memory, one burst in flight per direction.
// Define AXI_SLV_STALL_EN to add LFSR-driven AWREADY/WREADY/ARREADY stalls.
module axi4_mem_responder #(
    parameter int                    ID_WIDTH   = 1,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [15:0]           STALL_SEED = 16'hACE1
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [ID_WIDTH-1:0]   S_AXI_AWID,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [7:0]            S_AXI_AWLEN,
    input  logic [2:0]            S_AXI_AWSIZE,
    input  logic [1:0]            S_AXI_AWBURST,
    input  logic [1:0]            S_AXI_AWLOCK,
    input  logic [3:0]            S_AXI_AWCACHE,
    input  logic [2:0]            S_AXI_AWPROT,
    input  logic [3:0]            S_AXI_AWREGION,
    input  logic [3:0]            S_AXI_AWQOS,
    input  logic                  S_AXI_AWUSER,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WLAST,
    input  logic                  S_AXI_WID,
    input  logic                  S_AXI_WUSER,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [ID_WIDTH-1:0]   S_AXI_BID,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BUSER,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]            S_AXI_ARLEN,
    input  logic [2:0]            S_AXI_ARSIZE,
    input  logic [1:0]            S_AXI_ARBURST,
    input  logic [1:0]            S_AXI_ARLOCK,
    input  logic [3:0]            S_AXI_ARCACHE,
    input  logic [2:0]            S_AXI_ARPROT,
    input  logic [3:0]            S_AXI_ARREGION,
    input  logic [3:0]            S_AXI_ARQOS,
    input  logic                  S_AXI_ARUSER,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [ID_WIDTH-1:0]   S_AXI_RID,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RLAST,
    output logic                  S_AXI_RUSER,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY
);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * 4);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic in_range(input addr_t a);
        addr_t off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ({1'b0, off} < MEM_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input addr_t a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic burst_bad(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [7:0] len, input logic [1:0] lsb);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size != 3'b010) || (burst == 2'b11) ||
               ((burst == BURST_WRAP) && !wrap_len_ok) || (lsb != 2'b00);
    endfunction

    // WRAP mask is boundary-1 where boundary = (len+1)*4.
    function automatic addr_t next_addr(input addr_t a, input logic [7:0] len,
                                        input logic [1:0] burst);
        addr_t mask;
        mask = ADDR_WIDTH'({len, 2'b11});
        unique case (1'b1)
            burst == BURST_FIXED: return a;
            burst == BURST_WRAP:  return (a & ~mask) | ((a + ADDR_WIDTH'(4)) & mask);
            default:              return a + ADDR_WIDTH'(4);
        endcase
    endfunction

    logic [31:0] mem [MEM_DEPTH];
    logic        stall;

    w_state_e          w_state_q, w_state_d;
    logic [ID_WIDTH-1:0] wid_q, wid_d;
    addr_t             waddr_q, waddr_d;
    logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [1:0]        wburst_q, wburst_d, bresp_q, bresp_d;
    logic              wbad_q, wbad_d, werr_q, werr_d;
    logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic              aw_hs, w_hs, b_hs, mem_we, w_last_cnt, w_beat_err;
    logic [IDX_W-1:0]  w_idx;

    r_state_e          r_state_q, r_state_d;
    logic [ID_WIDTH-1:0] rid_q, rid_d;
    addr_t             raddr_q, raddr_d, r_rd_addr;
    logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [1:0]        rburst_q, rburst_d, rresp_q, rresp_d;
    logic              rbad_q, rbad_d, rlast_q, rlast_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d, r_word;
    logic              ar_hs, r_hs, r_bad_now, r_beat_err;

`ifdef AXI_SLV_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) lfsr_q <= STALL_SEED;
        else          lfsr_q <= lfsr_d;
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWREGION,
                         S_AXI_AWQOS, S_AXI_AWUSER, S_AXI_ARLOCK, S_AXI_ARCACHE,
                         S_AXI_ARPROT, S_AXI_ARREGION, S_AXI_ARQOS, S_AXI_ARUSER,
                         S_AXI_WID, S_AXI_WUSER, STALL_SEED};

    assign S_AXI_AWREADY = awready_q & ~stall;
    assign S_AXI_WREADY  = wready_q & ~stall;
    assign S_AXI_ARREADY = arready_q & ~stall;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_BID     = wid_q;
    assign S_AXI_BUSER   = 1'b0;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RID     = rid_q;
    assign S_AXI_RUSER   = 1'b0;

    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
    assign b_hs  = S_AXI_BVALID & S_AXI_BREADY;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
    assign r_hs  = S_AXI_RVALID & S_AXI_RREADY;

    always_comb begin
        w_state_d  = w_state_q;
        wid_d      = wid_q;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wburst_d   = wburst_q;
        wbad_d     = wbad_q;
        wcnt_d     = wcnt_q;
        werr_d     = werr_q;
        bresp_d    = bresp_q;
        mem_we     = 1'b0;
        w_last_cnt = (wcnt_q == wlen_q);
        w_beat_err = wbad_q || !in_range(waddr_q);
        w_idx      = word_idx(waddr_q);
        unique case (w_state_q)
            W_IDLE: if (aw_hs) begin
                wid_d     = S_AXI_AWID;
                waddr_d   = S_AXI_AWADDR;
                wlen_d    = S_AXI_AWLEN;
                wburst_d  = S_AXI_AWBURST;
                wbad_d    = burst_bad(S_AXI_AWSIZE, S_AXI_AWBURST,
                                      S_AXI_AWLEN, S_AXI_AWADDR[1:0]);
                wcnt_d    = 8'd0;
                werr_d    = 1'b0;
                w_state_d = W_DATA;
            end
            W_DATA: if (w_hs) begin
                mem_we  = !w_beat_err;
                werr_d  = werr_q | w_beat_err | (S_AXI_WLAST != w_last_cnt);
                wcnt_d  = wcnt_q + 8'd1;
                waddr_d = next_addr(waddr_q, wlen_q, wburst_q);
                if (w_last_cnt) begin
                    w_state_d = W_RESP;
                    bresp_d   = werr_d ? RESP_SLVERR : RESP_OKAY;
                end
            end
            W_RESP: if (b_hs) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Beat 0 is fetched from ARADDR in the handshake cycle itself.
    always_comb begin
        r_state_d  = r_state_q;
        rid_d      = rid_q;
        raddr_d    = raddr_q;
        rlen_d     = rlen_q;
        rburst_d   = rburst_q;
        rbad_d     = rbad_q;
        rcnt_d     = rcnt_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        r_rd_addr  = (r_state_q == R_IDLE) ? S_AXI_ARADDR : raddr_q;
        r_bad_now  = (r_state_q == R_IDLE) ?
                     burst_bad(S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLEN, S_AXI_ARADDR[1:0]) :
                     rbad_q;
        r_beat_err = r_bad_now || !in_range(r_rd_addr);
        r_word     = mem[word_idx(r_rd_addr)];
        unique case (r_state_q)
            R_IDLE: if (ar_hs) begin
                rid_d     = S_AXI_ARID;
                rlen_d    = S_AXI_ARLEN;
                rburst_d  = S_AXI_ARBURST;
                rbad_d    = r_bad_now;
                rcnt_d    = 8'd0;
                raddr_d   = next_addr(S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST);
                rdata_d   = r_beat_err ? 32'd0 : r_word;
                rresp_d   = r_beat_err ? RESP_SLVERR : RESP_OKAY;
                rlast_d   = (S_AXI_ARLEN == 8'd0);
                r_state_d = R_DATA;
            end
            R_DATA: if (r_hs) begin
                if (rlast_q) begin
                    rlast_d   = 1'b0;
                    r_state_d = R_IDLE;
                end else begin
                    rcnt_d  = rcnt_q + 8'd1;
                    raddr_d = next_addr(raddr_q, rlen_q, rburst_q);
                    rdata_d = r_beat_err ? 32'd0 : r_word;
                    rresp_d = r_beat_err ? RESP_SLVERR : RESP_OKAY;
                    rlast_d = (rcnt_d == rlen_q);
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_q <= W_IDLE;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wburst_q  <= '0;
            wbad_q    <= 1'b0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            bresp_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rburst_q  <= '0;
            rbad_q    <= 1'b0;
            rcnt_q    <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            wid_q     <= wid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wburst_q  <= wburst_d;
            wbad_q    <= wbad_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            bresp_q   <= bresp_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rburst_q  <= rburst_d;
            rbad_q    <= rbad_d;
            rcnt_q    <= rcnt_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Contents survive reset; a same-cycle read sees the pre-write word.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (S_AXI_WSTRB[b]) mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder: bursts, strobes, wrap, range errors,
// back-pressure and mid-burst reset.
module tb_axi4_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:0]  awid = '0, arid = '0, bid, rid;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [2:0]  awsize = 3'd2, arsize = 3'd2;
    logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 0, awready, wlast = 0, wvalid = 0, wready;
    logic        bvalid, bready = 0, buser, arvalid = 0, arready;
    logic        rlast, rvalid, rready = 0, ruser;

    int checks = 0;
    int errors = 0;

    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    logic [31:0] rbuf [16];
    logic [1:0]  rrbuf [16];
    logic        rlbuf [16];
    logic [1:0]  resp;

    always #5 clk = ~clk;

    axi4_mem_responder dut (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
        .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst), .S_AXI_AWLOCK(2'b00),
        .S_AXI_AWCACHE(4'h0), .S_AXI_AWPROT(3'h0), .S_AXI_AWREGION(4'h0),
        .S_AXI_AWQOS(4'h0), .S_AXI_AWUSER(1'b0), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WLAST(wlast), .S_AXI_WID(1'b0), .S_AXI_WUSER(1'b0),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_BID(bid),
        .S_AXI_BRESP(bresp), .S_AXI_BUSER(buser), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready), .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr),
        .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
        .S_AXI_ARLOCK(2'b00), .S_AXI_ARCACHE(4'h0), .S_AXI_ARPROT(3'h0),
        .S_AXI_ARREGION(4'h0), .S_AXI_ARQOS(4'h0), .S_AXI_ARUSER(1'b0),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_RID(rid),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RUSER(ruser), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int bdly,
                            output logic [1:0] r);
        logic hs;
        int n;
        logic [1:0] snap;
        awaddr = addr; awlen = len; awburst = burst; awvalid = 1;
        hs = 0; n = 0;
        while (!hs && n < 50) begin
            @(negedge clk); hs = awready; @(posedge clk); #1; n++;
        end
        awvalid = 0;
        chk("aw_hs", hs, 1);
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == int'(len)); wvalid = 1;
            hs = 0; n = 0;
            while (!hs && n < 50) begin
                @(negedge clk); hs = wready; @(posedge clk); #1; n++;
            end
            chk("w_hs", hs, 1);
        end
        wvalid = 0; wlast = 0;
        hs = 0; n = 0;
        while (!hs && n < 50) begin
            @(negedge clk); hs = bvalid; @(posedge clk); #1; n++;
        end
        chk("b_valid", hs, 1);
        snap = bresp;
        repeat (bdly) begin
            chk("b_hold", {bvalid, bresp}, {1'b1, snap});
            @(posedge clk); #1;
        end
        bready = 1;
        @(negedge clk); r = bresp;
        @(posedge clk); #1; bready = 0;
        @(negedge clk); chk("b_done", bvalid, 0);
        @(posedge clk); #1;
    endtask

    task automatic ar_req(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
        logic hs;
        int n;
        araddr = addr; arlen = len; arburst = burst; arvalid = 1;
        hs = 0; n = 0;
        while (!hs && n < 50) begin
            @(negedge clk); hs = arready; @(posedge clk); #1; n++;
        end
        arvalid = 0;
        chk("ar_hs", hs, 1);
    endtask

    task automatic r_beat(input int i);
        logic hs;
        int n;
        rready = 1; hs = 0; n = 0;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = rvalid;
            if (hs) begin rbuf[i] = rdata; rrbuf[i] = rresp; rlbuf[i] = rlast; end
            @(posedge clk); #1; n++;
        end
        chk("r_hs", hs, 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int hold);
        logic hs;
        int n;
        logic [34:0] snap;
        ar_req(addr, len, burst);
        for (int i = 0; i <= int'(len); i++) begin
            if (i == hold) begin
                rready = 0; hs = 0; n = 0;
                while (!hs && n < 50) begin
                    @(negedge clk); hs = rvalid;
                    if (!hs) begin @(posedge clk); #1; end
                    n++;
                end
                snap = {rdata, rresp, rlast};
                @(posedge clk); #1;
                repeat (5) begin
                    chk("r_hold", {rvalid, rdata, rresp, rlast}, {1'b1, snap});
                    @(posedge clk); #1;
                end
            end
            r_beat(i);
        end
        rready = 0;
        @(negedge clk); chk("r_done", rvalid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_valids", {bvalid, rvalid, rlast}, 3'b000);
        chk("rst_data", {rdata, bresp, rresp}, 36'h0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        chk("rel_readies", {awready, arready}, 2'b11);

        // INCR write/read with B and R back-pressure
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        for (int i = 0; i < 4; i++) sbuf[i] = 4'hF;
        do_write(32'h10, 8'd3, 2'b01, 3, resp);
        chk("incr_bresp", resp, 2'b00);
        do_read(32'h10, 8'd3, 2'b01, 2);
        chk("incr_d0", rbuf[0], 32'h11);
        chk("incr_d1", rbuf[1], 32'h22);
        chk("incr_d2", rbuf[2], 32'h33);
        chk("incr_d3", rbuf[3], 32'h44);
        for (int i = 0; i < 4; i++) begin
            chk("incr_rresp", rrbuf[i], 2'b00);
            chk("incr_rlast", rlbuf[i], (i == 3));
        end

        // byte strobes
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'hF;
        do_write(32'h20, 8'd0, 2'b01, 0, resp);
        chk("strb_bresp0", resp, 2'b00);
        wbuf[0] = 32'h00001122; sbuf[0] = 4'b0011;
        do_write(32'h20, 8'd0, 2'b01, 0, resp);
        chk("strb_bresp1", resp, 2'b00);
        do_read(32'h20, 8'd0, 2'b01, -1);
        chk("strb_data", rbuf[0], 32'hAABB1122);
        chk("strb_rlast", rlbuf[0], 1);

        // WRAP read
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
        do_write(32'h30, 8'd3, 2'b01, 0, resp);
        chk("fill_bresp", resp, 2'b00);
        do_read(32'h38, 8'd3, 2'b10, -1);
        chk("wrap_d0", rbuf[0], 32'd3);
        chk("wrap_d1", rbuf[1], 32'd4);
        chk("wrap_d2", rbuf[2], 32'd1);
        chk("wrap_d3", rbuf[3], 32'd2);
        chk("wrap_rresp", {rrbuf[0], rrbuf[1], rrbuf[2], rrbuf[3]}, 8'h00);

        // top of memory: second beat out of range
        wbuf[0] = 32'hDEADBEEF; wbuf[1] = 32'h12345678;
        sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        do_write(32'hFFC, 8'd1, 2'b01, 0, resp);
        chk("top_bresp", resp, 2'b10);
        do_read(32'hFFC, 8'd1, 2'b01, -1);
        chk("top_d0", rbuf[0], 32'hDEADBEEF);
        chk("top_r0", rrbuf[0], 2'b00);
        chk("top_d1", rbuf[1], 32'h0);
        chk("top_r1", rrbuf[1], 2'b10);
        chk("top_rlast", {rlbuf[0], rlbuf[1]}, 2'b01);

        // illegal WRAP length: whole burst errored and dropped
        for (int i = 0; i < 3; i++) begin wbuf[i] = 32'h99; sbuf[i] = 4'hF; end
        do_write(32'h10, 8'd2, 2'b10, 0, resp);
        chk("badwrap_bresp", resp, 2'b10);
        do_read(32'h10, 8'd0, 2'b01, -1);
        chk("badwrap_keep", rbuf[0], 32'h11);

        // reserved burst type on read
        do_read(32'h10, 8'd0, 2'b11, -1);
        chk("badburst_d", rbuf[0], 32'h0);
        chk("badburst_r", rrbuf[0], 2'b10);

        // reset during beat 2 of an 8-beat read
        ar_req(32'h10, 8'd7, 2'b01);
        r_beat(0);
        r_beat(1);
        chk("rst_b0", rbuf[0], 32'h11);
        chk("rst_b1", rbuf[1], 32'h22);
        @(negedge clk);
        chk("rst_pre_rvalid", rvalid, 1);
        #1 rst_n = 0;
        #1 chk("rst_rvalid", rvalid, 0);
        chk("rst_arready_lo", arready, 0);
        rready = 0;
        @(posedge clk); #1;
        chk("rst_hold", {rvalid, arready, awready}, 3'b000);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        chk("rst_rel_ready", {arready, awready, rvalid}, 3'b110);
        do_read(32'h20, 8'd0, 2'b01, -1);
        chk("post_rst_d", rbuf[0], 32'hAABB1122);
        chk("post_rst_r", {rrbuf[0], rlbuf[0]}, 3'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_mem_responder.md
Name: axi4_mem_responder

Overview:
- Synthesizable AXI4 slave (responder) that answers the team's AXI4 master BFM on the S_AXI_* bus.
- Backed by an internal word memory, with one outstanding transaction per direction.
- Read and write paths run independently.
- Supports FIXED/INCR/WRAP bursts, byte strobes and SLVERR for illegal or out-of-range accesses.
- Serves as the protocol-checking endpoint for master-side benches.

Parameters:
ID_WIDTH, 1, width of AWID/BID/ARID/RID
ADDR_WIDTH, 32, byte address width
MEM_DEPTH, 1024, memory size in 32-bit words (power of 2)
BASE_ADDR, 32'h0000_0000, byte address of word 0
STALL_SEED, 16'hACE1, LFSR seed (optional feature only)

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETN  in  1  reset, asynchronous assert, active-low
S_AXI_AWID / S_AXI_ARID  in  ID_WIDTH  write/read transaction ID
S_AXI_AWADDR / S_AXI_ARADDR  in  ADDR_WIDTH  start byte address
S_AXI_AWLEN / S_AXI_ARLEN  in  8  beats-1
S_AXI_AWSIZE / S_AXI_ARSIZE  in  3  only 3'b010 legal
S_AXI_AWBURST / S_AXI_ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 illegal
S_AXI_{AW,AR}{LOCK,CACHE,PROT,REGION,QOS,USER}  in  2/4/3/4/4/1  accepted, ignored
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WLAST  in  1  last write beat
S_AXI_WID, S_AXI_WUSER  in  1  ignored
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake
S_AXI_BID  out  ID_WIDTH  echoes captured AWID
S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_BUSER / S_AXI_RUSER  out  1  tied 0
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake
S_AXI_RID  out  ID_WIDTH  echoes captured ARID
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  per-beat response
S_AXI_RLAST  out  1  last read beat
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake

Behaviour:
- Reset (ARESETN low):
  - All ready/valid outputs and RLAST go to 0.
  - RDATA, BRESP, RRESP, BID and RID go to 0.
  - Both FSMs go to IDLE.
  - Memory contents are not reset.
  - AWREADY/ARREADY assert from the first clock edge after release.
  - Reset mid-burst abandons the transaction; no B or R response is issued.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1. On AW handshake, capture ID/addr/len/burst/size, set err=0 and move to W_DATA.
  - W_DATA: AWREADY=0, WREADY=1. Each W handshake writes only the strobed bytes.
  - The beat counter counts to AWLEN. On the counted last beat, move to W_RESP.
  - WLAST≠(count==AWLEN) sets err; completion follows the count.
  - W_RESP: BVALID=1, BRESP=err?SLVERR:OKAY, held stable until BREADY. Return to W_IDLE on handshake; the next AW can be accepted the following cycle.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. On AR handshake, capture fields.
  - RVALID rises one cycle after the AR handshake, with beat 0 registered in RDATA.
  - RDATA/RRESP/RLAST are held stable while RVALID && !RREADY.
  - On an R handshake with beats remaining, the next beat is presented the next cycle with RVALID kept high (1 beat/cycle).
  - RLAST=1 on beat ARLEN. Its handshake returns the FSM to R_IDLE.
- Address sequencing, byte address A:
  - FIXED: A is constant.
  - INCR: A += 4 per beat.
  - WRAP: boundary=(LEN+1)*4. A=(A&~(boundary-1)) | ((A+4)&(boundary-1)).
- Error rules:
  - SLVERR for the whole burst when SIZE≠2, BURST=11, WRAP with LEN not in {1,3,7,15}, or start address unaligned (A[1:0]≠0).
  - Per beat: address outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*4) gives SLVERR for that beat.
  - An errored write beat is dropped.
  - An errored read beat returns RDATA=0, RRESP=SLVERR.
  - BRESP=SLVERR if any beat erred.
- Same-cycle read and write to the same word: the read captures the old value; the write is visible from the next cycle.
- INCR past the memory top is treated as out of range, with no wrap into word 0.

Optional Feature:
- AXI_SLV_STALL_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seeded STALL_SEED at reset) advances every cycle.
  - When lfsr[0]=1, AWREADY, WREADY and ARREADY are forced 0 that cycle.
  - BVALID/RVALID are never gated.
- Undefined: readies follow FSM state only; no LFSR logic is present.

Test Plan:
- Write AW addr 0x10, LEN 3, INCR, WDATA 0x11..0x44, STRB F, then read same -> BRESP OKAY; RDATA 0x11,0x22,0x33,0x44; RLAST on beat 3 only.
- Write 0xAABBCCDD to 0x20 STRB F, then 0x00001122 STRB 0011 -> read 0x20 returns 0xAABB1122.
- WRAP read addr 0x38, LEN 3 after filling 0x30..0x3C with 1..4 -> RDATA 3,4,1,2, all OKAY.
- Write LEN 1 at BASE+MEM_DEPTH*4-4 -> first beat stored, second dropped, BRESP SLVERR; read LEN 1 same addr -> RRESP OKAY then SLVERR with RDATA 0.
- RREADY low 5 cycles mid-burst and BREADY delayed 3 cycles -> RDATA/RLAST/BVALID/BRESP stable; no beat lost or duplicated.
- ARESETN pulsed low during beat 2 of an 8-beat read -> RVALID 0 immediately; ARREADY 1 on the first edge after release; a new read completes normally.
